// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the ring-oscillator TDC: runs 2^AVG_LOG2 start/stop
// measurements per arm, averages the counts and guards each one with a timeout.
module tdc_meas_ctrl #(
   parameter int CNT_W      = 32,
   parameter int AVG_LOG2   = 2,
   parameter int TIMEOUT_W  = 20,
   parameter int SETTLE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             arm,
   input  logic             start_in,
   input  logic             stop_in,
   input  logic [CNT_W-1:0] tdc_count,
   output logic             tdc_clear,
   output logic             tdc_enable,
   output logic             busy,
   output logic             done,
   output logic             timeout_flag,
   output logic [CNT_W-1:0] result,
   input  logic [1:0]       byte_sel,
   output logic [7:0]       byte_out
);

   localparam int ACC_W = CNT_W + AVG_LOG2;
   localparam int SC_W  = AVG_LOG2 + 1;
   localparam int ST_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int PAD_W = (CNT_W > 32) ? CNT_W : 32;
   // Timeout fires on the edge where the counter would reach all ones.
   localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
   localparam logic [SC_W-1:0]      SC_LAST = SC_W'((1 << AVG_LOG2) - 1);
   localparam logic [ST_W-1:0]      ST_LAST = ST_W'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {
      IDLE, CLEAR, WAIT_START, WAIT_STOP, SETTLE, ACCUM, DONE
   } state_t;

   state_t               state, state_nxt;
   logic [1:0]           start_sync, stop_sync;
   logic                 start_d, stop_d, start_edge, stop_edge;
   logic [TIMEOUT_W-1:0] tcnt;
   logic [ST_W-1:0]      settle_cnt;
   logic [SC_W-1:0]      sample_cnt;
   logic [ACC_W-1:0]     acc;
   logic                 timeout_hit;
   logic [PAD_W-1:0]     res_pad;

   always_ff @(posedge clk) begin
      if (rst) begin
         start_sync <= '0;
         stop_sync  <= '0;
         start_d    <= 1'b0;
         stop_d     <= 1'b0;
         start_edge <= 1'b0;
         stop_edge  <= 1'b0;
      end else begin
         start_sync <= {start_sync[0], start_in};
         stop_sync  <= {stop_sync[0], stop_in};
         start_d    <= start_sync[1];
         stop_d     <= stop_sync[1];
         start_edge <= start_sync[1] & ~start_d;
         stop_edge  <= stop_sync[1] & ~stop_d;
      end
   end

   always_comb begin
      state_nxt   = state;
      timeout_hit = 1'b0;
      unique case (state)
         IDLE:       if (arm) state_nxt = CLEAR;
         CLEAR:      state_nxt = WAIT_START;
         WAIT_START: begin
            // Start has priority; a coincident stop edge is simply not looked at.
            if (start_edge) state_nxt = WAIT_STOP;
            else if (tcnt == TO_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end
         end
         WAIT_STOP: begin
            if (stop_edge) state_nxt = SETTLE;
            else if (tcnt == TO_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end
         end
         SETTLE:     if (settle_cnt == ST_LAST) state_nxt = ACCUM;
         ACCUM:      state_nxt = (sample_cnt == SC_LAST) ? DONE : CLEAR;
         DONE:       state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         tdc_clear    <= 1'b0;
         tdc_enable   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         timeout_flag <= 1'b0;
         result       <= '0;
         tcnt         <= '0;
         settle_cnt   <= '0;
         sample_cnt   <= '0;
         acc          <= '0;
      end else begin
         state      <= state_nxt;
         tdc_clear  <= (state_nxt == CLEAR);
         tdc_enable <= (state_nxt == WAIT_START) || (state_nxt == WAIT_STOP);
         busy       <= (state_nxt != IDLE);
         done       <= 1'b0;
         unique case (state)
            IDLE: if (arm) begin
               timeout_flag <= 1'b0;
               acc          <= '0;
               sample_cnt   <= '0;
            end
            CLEAR:      tcnt <= '0;
            WAIT_START: tcnt <= start_edge ? '0 : tcnt + 1'b1;
            WAIT_STOP: begin
               tcnt       <= tcnt + 1'b1;
               settle_cnt <= '0;
            end
            SETTLE:     settle_cnt <= settle_cnt + 1'b1;
            ACCUM: begin
               acc        <= acc + ACC_W'(tdc_count);
               sample_cnt <= sample_cnt + 1'b1;
            end
            DONE: begin
               result <= CNT_W'(acc >> AVG_LOG2);
               done   <= 1'b1;
            end
            default: ;
         endcase
         if (timeout_hit) begin
            result       <= '1;
            timeout_flag <= 1'b1;
            done         <= 1'b1;
         end
      end
   end

   assign res_pad = PAD_W'(result);

   always_comb begin
      byte_out = '0;
      if (32'(byte_sel) < 32'(CNT_W / 8)) byte_out = res_pad[{byte_sel, 3'b000} +: 8];
   end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed self-checking bench for tdc_meas_ctrl (AVG_LOG2=2, TIMEOUT_W=8, SETTLE_CYC=2).
module tb_tdc_meas_ctrl;

   logic        clk = 1'b0;
   logic        rst, arm, start_in, stop_in;
   logic [31:0] tdc_count;
   logic        tdc_clear, tdc_enable, busy, done, timeout_flag;
   logic [31:0] result;
   logic [1:0]  byte_sel;
   logic [7:0]  byte_out;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int clear_cnt = 0;
   int overlap_cnt = 0;

   tdc_meas_ctrl #(
      .CNT_W(32), .AVG_LOG2(2), .TIMEOUT_W(8), .SETTLE_CYC(2)
   ) dut (
      .clk(clk), .rst(rst), .arm(arm), .start_in(start_in), .stop_in(stop_in),
      .tdc_count(tdc_count), .tdc_clear(tdc_clear), .tdc_enable(tdc_enable),
      .busy(busy), .done(done), .timeout_flag(timeout_flag), .result(result),
      .byte_sel(byte_sel), .byte_out(byte_out)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (tdc_clear === 1'b1) clear_cnt++;
      if (tdc_clear === 1'b1 && tdc_enable === 1'b1) overlap_cnt++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_enable(input logic lvl, input string tag);
      int n;
      n = 0;
      while (tdc_enable !== lvl && n < 60) begin
         step();
         n++;
      end
      checks++;
      if (tdc_enable !== lvl) begin
         errors++;
         $display("FAIL %s: tdc_enable=%b required %b within 60 cycles", tag, tdc_enable, lvl);
      end
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      arm = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s: done=%b required 1 within 100 cycles", tag, done);
      end
   endtask

   task automatic do_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   // One start/stop measurement; returns in the first SETTLE cycle.
   task automatic do_meas(input logic [31:0] val, input bit simul, input bit arm_mid);
      wait_enable(1'b1, "meas_wait_start");
      if (simul) begin
         tdc_count = 32'd999;
         stop_in   = 1'b1;
      end
      start_in = 1'b1;
      step();
      step();
      start_in = 1'b0;
      stop_in  = 1'b0;
      repeat (6) step();
      if (arm_mid) do_arm();
      tdc_count = val;
      stop_in   = 1'b1;
      step();
      step();
      stop_in = 1'b0;
      wait_enable(1'b0, "meas_settle");
   endtask

   task automatic test_reset();
      rst = 1'b1; arm = 1'b1; start_in = 1'b1; stop_in = 1'b0;
      tdc_count = '0; byte_sel = 2'd0;
      repeat (20) begin
         step();
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || byte_out !== 8'd0 ||
             tdc_enable !== 1'b0 || tdc_clear !== 1'b0 || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h byte_out=%h en=%b clr=%b to=%b required all 0",
                     busy, done, result, byte_out, tdc_enable, tdc_clear, timeout_flag);
         end
      end
      arm = 1'b0; start_in = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      repeat (5) step();
      checks++;
      if (busy !== 1'b0 || done_cnt != 0) begin
         errors++;
         $display("FAIL reset_release: busy=%b done_count=%0d required 0/0", busy, done_cnt);
      end
   endtask

   task automatic test_average();
      int d0, c0;
      d0 = done_cnt; c0 = clear_cnt;
      do_arm();
      do_meas(32'd100, 1'b0, 1'b0);
      do_meas(32'd104, 1'b0, 1'b0);
      do_meas(32'd96,  1'b0, 1'b0);
      do_meas(32'd108, 1'b0, 1'b0);
      wait_done("avg_done");
      checks++;
      if (result !== 32'd102) begin
         errors++;
         $display("FAIL avg_result: got %0d required 102", result);
      end
      byte_sel = 2'd0; #1;
      checks++;
      if (byte_out !== 8'h66) begin
         errors++;
         $display("FAIL avg_byte0: got %h required 66", byte_out);
      end
      byte_sel = 2'd1; #1;
      checks++;
      if (byte_out !== 8'h00) begin
         errors++;
         $display("FAIL avg_byte1: got %h required 00", byte_out);
      end
      repeat (3) step();
      checks++;
      if (done_cnt - d0 != 1 || clear_cnt - c0 != 4) begin
         errors++;
         $display("FAIL avg_pulses: done=%0d clears=%0d required 1 and 4", done_cnt - d0, clear_cnt - c0);
      end
      checks++;
      if (busy !== 1'b0 || timeout_flag !== 1'b0) begin
         errors++;
         $display("FAIL avg_idle: busy=%b timeout_flag=%b required 0/0", busy, timeout_flag);
      end
   endtask

   task automatic test_timeout();
      int n;
      do_arm();
      wait_enable(1'b1, "to_wait_start");
      start_in = 1'b1;
      n = 0;
      while (done !== 1'b1 && n < 400) begin
         step();
         n++;
         if (n == 2) start_in = 1'b0;
      end
      // Raw rise -> edge at 3, counter cleared at 4, then 255 counts.
      checks++;
      if (n != 259) begin
         errors++;
         $display("FAIL to_latency: done after %0d cycles required 259", n);
      end
      checks++;
      if (timeout_flag !== 1'b1 || result !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL to_result: flag=%b result=%h required 1/ffffffff", timeout_flag, result);
      end
      byte_sel = 2'd3; #1;
      checks++;
      if (byte_out !== 8'hFF) begin
         errors++;
         $display("FAIL to_byte3: got %h required ff", byte_out);
      end
      step();
      checks++;
      if (busy !== 1'b0 || timeout_flag !== 1'b1) begin
         errors++;
         $display("FAIL to_sticky: busy=%b flag=%b required 0/1", busy, timeout_flag);
      end
      do_arm();
      checks++;
      if (timeout_flag !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL to_rearm: flag=%b busy=%b required 0/1", timeout_flag, busy);
      end
      do_meas(32'd10, 1'b0, 1'b0);
      do_meas(32'd20, 1'b0, 1'b0);
      do_meas(32'd30, 1'b0, 1'b0);
      do_meas(32'd40, 1'b0, 1'b0);
      wait_done("to_recover_done");
      checks++;
      if (result !== 32'd25 || timeout_flag !== 1'b0) begin
         errors++;
         $display("FAIL to_recover: result=%0d flag=%b required 25/0", result, timeout_flag);
      end
      step();
   endtask

   task automatic test_simultaneous();
      do_arm();
      do_meas(32'd204, 1'b1, 1'b0);
      do_meas(32'd200, 1'b0, 1'b0);
      do_meas(32'd200, 1'b0, 1'b0);
      do_meas(32'd200, 1'b0, 1'b0);
      wait_done("simul_done");
      checks++;
      if (result !== 32'd201) begin
         errors++;
         $display("FAIL simul_result: got %0d required 201", result);
      end
      step();
   endtask

   task automatic test_arm_ignored();
      int d0;
      d0 = done_cnt;
      do_arm();
      do_meas(32'd7,  1'b0, 1'b1);
      do_meas(32'd8,  1'b0, 1'b1);
      do_meas(32'd9,  1'b0, 1'b0);
      do_meas(32'd10, 1'b0, 1'b1);
      arm = 1'b1;
      wait_done("arm_done");
      checks++;
      if (result !== 32'd8) begin
         errors++;
         $display("FAIL arm_result: got %0d required 8", result);
      end
      repeat (10) step();
      checks++;
      if (done_cnt - d0 != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL arm_single_done: done=%0d busy=%b required 1/0", done_cnt - d0, busy);
      end
   endtask

   task automatic test_reset_settle();
      int d0;
      do_arm();
      do_meas(32'd77, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b1 || tdc_enable !== 1'b0) begin
         errors++;
         $display("FAIL rs_in_settle: busy=%b en=%b required 1/0", busy, tdc_enable);
      end
      d0 = done_cnt;
      rst = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0 || tdc_enable !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
         errors++;
         $display("FAIL rs_abort: busy=%b en=%b done=%b result=%0d required 0/0/0/0",
                  busy, tdc_enable, done, result);
      end
      rst = 1'b0;
      repeat (20) step();
      checks++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rs_quiet: extra done=%0d busy=%b required 0/0", done_cnt - d0, busy);
      end
      do_arm();
      repeat (4) do_meas(32'd50, 1'b0, 1'b0);
      wait_done("rs_burst_done");
      checks++;
      if (result !== 32'd50) begin
         errors++;
         $display("FAIL rs_burst_result: got %0d required 50", result);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_average();
      test_timeout();
      test_simultaneous();
      test_arm_ignored();
      test_reset_settle();
      checks++;
      if (overlap_cnt != 0) begin
         errors++;
         $display("FAIL clear_enable_overlap: %0d cycles required 0", overlap_cnt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
